// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers.
// Defaults describe 640x480 at 60 Hz.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 11;

  function automatic int axis_total(
    input int active,
    input int fp,
    input int sync,
    input int bp
  );
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus
// sync/active decode of the next count value.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = DEF_H_ACTIVE,
  parameter int   FP     = DEF_H_FP,
  parameter int   SYNC   = DEF_H_SYNC,
  parameter int   BP     = DEF_H_BP,
  parameter logic POL    = 1'b0,
  parameter int   CW     = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          sync,
  output logic          active
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_param
    $error("vga_axis_counter: timing parameters must be nonzero");
  end
  if (CW < 1 || CW > 30 || TOTAL > (1 << CW)) begin : g_bad_width
    $error("vga_axis_counter: total does not fit in CW bits");
  end

  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_HI = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    wrap  = inc && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Decoded from cnt_d so the parent can register them in step with cnt.
  assign cnt    = cnt_q;
  assign sync   = ((cnt_d >= SYNC_LO) && (cnt_d < SYNC_HI)) ? POL : ~POL;
  assign active = (cnt_d < ACT_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: x/y counters with
// registered, zero-skew sync, display-enable and start strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  logic h_wrap, h_sync, h_act;
  logic v_inc, v_wrap, v_sync, v_act;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC),
    .BP(H_BP), .POL(HS_POL), .CW(CW)
  ) u_h (
    .clk(clk), .reset(reset), .inc(pix_en),
    .cnt(x), .wrap(h_wrap), .sync(h_sync), .active(h_act)
  );

  assign v_inc = h_wrap & pix_en;

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC),
    .BP(V_BP), .POL(VS_POL), .CW(CW)
  ) u_v (
    .clk(clk), .reset(reset), .inc(v_inc),
    .cnt(y), .wrap(v_wrap), .sync(v_sync), .active(v_act)
  );

  logic hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic ls_q, ls_d, fs_q, fs_d;

  always_comb begin
    hs_d = hs_q;
    vs_d = vs_q;
    de_d = de_q;
    ls_d = 1'b0;
    fs_d = 1'b0;
    if (pix_en) begin
      hs_d = h_sync;
      vs_d = v_sync;
      de_d = h_act & v_act;
      ls_d = h_wrap;
      fs_d = v_wrap;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus
// a tiny-raster instance, checked against a pixel-count model.
module tb_vga_timing_gen;

  localparam int SHA = 4, SHF = 1, SHS = 1, SHB = 1;
  localparam int SVA = 2, SVF = 1, SVS = 1, SVB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, en_d, rst_s, en_s;
  logic hs_d, vs_d, de_d, ls_d, fs_d;
  logic hs_s, vs_s, de_s, ls_s, fs_s;
  logic [10:0] x_d, y_d, x_s, y_s;

  int checks = 0;
  int fails  = 0;

  vga_timing_gen u_dflt (
    .clk(clk), .reset(rst_d), .pix_en(en_d),
    .hsync(hs_d), .vsync(vs_d), .de(de_d),
    .x(x_d), .y(y_d),
    .line_start(ls_d), .frame_start(fs_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(11)
  ) u_tiny (
    .clk(clk), .reset(rst_s), .pix_en(en_s),
    .hsync(hs_s), .vsync(vs_s), .de(de_s),
    .x(x_s), .y(y_s),
    .line_start(ls_s), .frame_start(fs_s)
  );

  // Model state: pixel strobes seen since reset, and whether the
  // latest clock edge carried a strobe.
  longint n_dm = 0, n_sm = 0;
  bit last_dm = 1'b0, last_sm = 1'b0;

  always @(posedge clk) begin
    if (!rst_d) begin
      n_dm <= 0; last_dm <= 1'b0;
    end else begin
      last_dm <= en_d;
      if (en_d) n_dm <= n_dm + 1;
    end
    if (!rst_s) begin
      n_sm <= 0; last_sm <= 1'b0;
    end else begin
      last_sm <= en_s;
      if (en_s) n_sm <= n_sm + 1;
    end
  end

  function automatic void model(
    input longint n, input bit last, input bit rn,
    input int ha, input int hf, input int hsw, input int hb,
    input int va, input int vf, input int vsw, input int vb,
    input bit hp, input bit vp,
    output int ex, output int ey,
    output bit ehs, output bit evs, output bit ede,
    output bit els, output bit efs
  );
    int ht, vt;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (!rn) begin
      ex = 0; ey = 0; ehs = !hp; evs = !vp;
      ede = 0; els = 0; efs = 0;
      return;
    end
    ex  = int'(n % ht);
    ey  = int'((n / ht) % vt);
    ehs = (ex >= ha + hf && ex < ha + hf + hsw) ? hp : !hp;
    evs = (ey >= va + vf && ey < va + vf + vsw) ? vp : !vp;
    ede = (n > 0) && (ex < ha) && (ey < va);
    els = last && (ex == 0);
    efs = els && (ey == 0);
  endfunction

  task automatic cmp(
    input string nm,
    input int ax, input int ay,
    input bit ahs, input bit avs, input bit ade,
    input bit als, input bit afs,
    input int ex, input int ey,
    input bit ehs, input bit evs, input bit ede,
    input bit els, input bit efs
  );
    checks++;
    if (ax != ex || ay != ey || ahs != ehs || avs != evs ||
        ade != ede || als != els || afs != efs) begin
      fails++;
      $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
               nm, $time, ax, ay, ahs, avs, ade, als, afs,
               ex, ey, ehs, evs, ede, els, efs);
    end
  endtask

  always @(negedge clk) begin
    int ex, ey;
    bit ehs, evs, ede, els, efs;
    model(n_dm, last_dm, rst_d, 640, 16, 96, 48, 480, 10, 2, 33,
          1'b0, 1'b0, ex, ey, ehs, evs, ede, els, efs);
    cmp("dflt", int'(x_d), int'(y_d), hs_d, vs_d, de_d, ls_d, fs_d,
        ex, ey, ehs, evs, ede, els, efs);
    model(n_sm, last_sm, rst_s, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB,
          1'b1, 1'b0, ex, ey, ehs, evs, ede, els, efs);
    cmp("tiny", int'(x_s), int'(y_s), hs_s, vs_s, de_s, ls_s, fs_s,
        ex, ey, ehs, evs, ede, els, efs);
  end

  task automatic lit(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fs(input int budget, output int c);
    c = -1;
    for (int i = 1; i <= budget && c < 0; i++) begin
      nxt();
      if (fs_s) c = i;
    end
  endtask

  initial begin
    int c, nde, nhs, nvs, nls;
    rst_d = 1'b0; rst_s = 1'b0;
    en_d  = 1'b0; en_s  = 1'b0;
    repeat (3) nxt();
    lit("rst x", int'(x_d), 0);
    lit("rst hsync", int'(hs_d), 1);
    lit("rst vsync", int'(vs_d), 1);
    lit("rst de", int'(de_d), 0);
    lit("tiny rst hsync", int'(hs_s), 0);

    rst_d = 1'b1; rst_s = 1'b1;
    repeat (2) nxt();
    lit("idle x", int'(x_d), 0);
    lit("idle fs", int'(fs_d), 0);

    en_d = 1'b1;
    nxt();
    lit("first x", int'(x_d), 1);
    lit("first y", int'(y_d), 0);
    lit("first fs", int'(fs_d), 0);
    lit("first de", int'(de_d), 1);
    repeat (654) nxt();
    lit("x655 hsync", int'(hs_d), 1);
    nxt();
    lit("x656 hsync", int'(hs_d), 0);
    repeat (95) nxt();
    lit("x751 hsync", int'(hs_d), 0);
    nxt();
    lit("x752 hsync", int'(hs_d), 1);
    repeat (47) nxt();
    lit("x799", int'(x_d), 799);
    nxt();
    lit("wrap x", int'(x_d), 0);
    lit("wrap y", int'(y_d), 1);
    lit("wrap ls", int'(ls_d), 1);
    lit("wrap fs", int'(fs_d), 0);

    en_d = 1'b0;
    nxt();
    lit("hold x", int'(x_d), 0);
    lit("hold ls", int'(ls_d), 0);
    nxt();
    en_d = 1'b1;
    repeat (700) nxt();
    lit("x700", int'(x_d), 700);
    lit("x700 hsync", int'(hs_d), 0);

    rst_d = 1'b0;
    #1;
    lit("async x", int'(x_d), 0);
    lit("async y", int'(y_d), 0);
    lit("async hsync", int'(hs_d), 1);
    lit("async de", int'(de_d), 0);
    repeat (2) nxt();
    rst_d = 1'b1;
    nxt();
    lit("rerun x", int'(x_d), 1);

    en_s = 1'b1;
    wait_fs(100, c);
    lit("tiny first fs delay", c, 35);
    nde = 0; nhs = 0; nvs = 0; nls = 0;
    for (int i = 1; i <= 35; i++) begin
      nxt();
      nde += int'(de_s);
      nhs += int'(hs_s);
      nvs += int'(!vs_s);
      nls += int'(ls_s);
      if (i == 34) begin
        lit("tiny last x", int'(x_s), 6);
        lit("tiny last y", int'(y_s), 4);
      end
    end
    lit("tiny de count", nde, 8);
    lit("tiny hsync high", nhs, 5);
    lit("tiny vsync low", nvs, 7);
    lit("tiny ls count", nls, 5);
    lit("tiny wrap fs", int'(fs_s), 1);
    lit("tiny wrap ls", int'(ls_s), 1);
    lit("tiny wrap x", int'(x_s), 0);
    lit("tiny wrap y", int'(y_s), 0);
    lit("tiny wrap de", int'(de_s), 1);

    en_s = 1'b0;
    c = -1;
    for (int i = 1; i <= 200 && c < 0; i++) begin
      nxt();
      if (fs_s) c = i;
      en_s = ~en_s;
    end
    lit("tiny toggled period", c, 70);

    en_s = 1'b1;
    repeat (40) nxt();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
